// File: rtl/arb_req_queue_pkg.sv
// Shared constants and helpers for the arbiter request queue.
// The port count is fixed by the downstream 4-port arbiter.
package arb_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;

  typedef logic [PORT_W-1:0] port_idx_t;

  // True when exactly one bit of the vector is set.
  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] vec);
    int count;
    count = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      count += int'(vec[i]);
    end
    return (count == 1);
  endfunction

  // Binary index of a one-hot vector; only meaningful when the input is one-hot.
  function automatic port_idx_t onehot_to_idx(input logic [NUM_PORTS-1:0] vec);
    port_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (vec[i]) begin
        idx = idx | port_idx_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_req_queue_req_fifo.sv
// Small per-port request FIFO with a combinational head output.
// Full and empty come from registered state only.
module req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic w_doPush;
  logic w_doPop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign head_data = r_mem[r_rdPtr];

  // A full FIFO refuses a push even if it is popped in the same cycle.
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_queue.sv
// Per-port request buffering in front of the rotating-priority arbiter;
// pops the granted port and registers its payload with the port index.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic [NUM_PORTS-1:0]        arb_req,
  output logic                        arb_en,
  input  logic [NUM_PORTS-1:0]        arb_gnt,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [PORT_W-1:0]           out_port,
  output logic                        gnt_err
);

  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_empty;
  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;
  logic [DATA_W-1:0]    w_head [NUM_PORTS];

  logic      w_gntOneHot;
  logic      w_gntLegal;
  logic      w_gntIllegal;
  port_idx_t w_gntIdx;

  logic              r_outValid;
  logic [DATA_W-1:0] r_outData;
  port_idx_t         r_outPort;
  logic              r_gntErr;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push[p]),
      .push_data (in_data[p*DATA_W +: DATA_W]),
      .pop       (w_pop[p]),
      .full      (w_full[p]),
      .empty     (w_empty[p]),
      .head_data (w_head[p])
    );
  end

  // in_ready depends on FIFO state only, so there is no path from arb_gnt.
  assign in_ready = ~w_full;
  assign arb_req  = ~w_empty;
  assign arb_en   = |arb_req;
  assign w_push   = in_valid & in_ready;

  // A grant is honoured only when it is one-hot and names a requesting port.
  assign w_gntOneHot  = is_onehot(arb_gnt);
  assign w_gntLegal   = w_gntOneHot && |(arb_gnt & arb_req);
  assign w_gntIllegal = |arb_gnt && !w_gntLegal;
  assign w_gntIdx     = onehot_to_idx(arb_gnt);
  assign w_pop        = arb_gnt & {NUM_PORTS{w_gntLegal}};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outPort  <= '0;
    end else begin
      r_outValid <= w_gntLegal;
      if (w_gntLegal) begin
        r_outData <= w_head[w_gntIdx];
        r_outPort <= w_gntIdx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_gntErr <= 1'b0;
    end else if (w_gntIllegal) begin
      r_gntErr <= 1'b1;
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_port  = r_outPort;
  assign gnt_err   = r_gntErr;

endmodule
